// File: rtl/exc_commit.sv
// Commit-stage exception sequencer: picks the highest-priority event on the
// writeback instruction, kills it, requests the CP0 event, holds the pipeline
// flushed until the data bus drains and hands the redirect PC to fetch.
// Optional: define EXC_STATS_EN to add exc_count/int_count/eret_count.
module exc_commit #(
  parameter int          OUT_W      = 3,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ws_valid,
  input  logic [31:0]      ws_pc,
  input  logic             ws_bd,
  input  logic [6:0]       ws_exc,
  input  logic             ws_eret,
  input  logic             ws_refetch,
  input  logic [31:0]      ws_daddr,
  input  logic [7:0]       cause_ip,
  input  logic [7:0]       status_im,
  input  logic             status_ie,
  input  logic             status_exl,
  input  logic [31:0]      epc,
  input  logic [OUT_W-1:0] outstanding,
  output logic             exception_like,
  output logic [4:0]       exccode,
  output logic             is_delay_slot,
  output logic [31:0]      pc,
  output logic [31:0]      badvaddr,
  output logic             ws_kill,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
`ifdef EXC_STATS_EN
  output logic [31:0]      exc_count,
  output logic [31:0]      int_count,
  output logic [31:0]      eret_count,
`endif
  input  logic             redirect_ready
);

  // CP0 event codes
  localparam logic [4:0] EXC_INT     = 5'h00;
  localparam logic [4:0] EXC_ADEL    = 5'h04;
  localparam logic [4:0] EXC_ADES    = 5'h05;
  localparam logic [4:0] EXC_SYS     = 5'h08;
  localparam logic [4:0] EXC_BP      = 5'h09;
  localparam logic [4:0] EXC_RI      = 5'h0a;
  localparam logic [4:0] EXC_OV      = 5'h0c;
  localparam logic [4:0] EXC_ERET    = 5'h1e;
  localparam logic [4:0] EXC_REFETCH = 5'h1f;

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;

  typedef struct packed {
    logic        hit;
    logic [4:0]  code;
    logic [31:0] bva;
    logic        is_int;
    logic        is_eret;
    logic        is_ref;
  } evt_t;

  state_t state, state_nx;
  evt_t   evt;
  logic   int_pend;

  assign int_pend = status_ie & ~status_exl & |(cause_ip & status_im);

  // Event arbitration; only a valid instruction in IDLE can raise an event
  always_comb begin
    evt = '0;
    if (state == IDLE && ws_valid) begin
      evt.hit = 1'b1;
      if (int_pend)           begin evt.code = EXC_INT; evt.is_int = 1'b1; end
      else if (ws_exc[0])     begin evt.code = EXC_ADEL; evt.bva = ws_pc; end
      else if (ws_exc[1])     evt.code = EXC_RI;
      else if (ws_exc[2])     evt.code = EXC_OV;
      else if (ws_exc[3])     evt.code = EXC_SYS;
      else if (ws_exc[4])     evt.code = EXC_BP;
      else if (ws_exc[5])     begin evt.code = EXC_ADEL; evt.bva = ws_daddr; end
      else if (ws_exc[6])     begin evt.code = EXC_ADES; evt.bva = ws_daddr; end
      else if (ws_eret)       begin evt.code = EXC_ERET; evt.is_eret = 1'b1; end
      else if (ws_refetch)    begin evt.code = EXC_REFETCH; evt.is_ref = 1'b1; end
      else                    evt.hit = 1'b0;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nx       = state;
    exception_like = 1'b0;
    exccode        = 5'h00;
    is_delay_slot  = 1'b0;
    pc             = 32'h0;
    badvaddr       = 32'h0;
    ws_kill        = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        if (evt.hit) begin
          exception_like = 1'b1;
          exccode        = evt.code;
          is_delay_slot  = ws_bd;
          pc             = ws_pc;
          badvaddr       = evt.bva;
          ws_kill        = 1'b1;
          flush          = 1'b1;
          state_nx       = (outstanding != '0) ? DRAIN : REDIRECT;
        end
      end
      DRAIN: begin
        flush = 1'b1;
        if (outstanding == '0) state_nx = REDIRECT;
      end
      REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and redirect target latched at commit
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      redirect_pc <= 32'h0;
    end else begin
      state <= state_nx;
      if (evt.hit)
        redirect_pc <= evt.is_eret ? epc : (evt.is_ref ? ws_pc : EXC_VECTOR);
    end
  end

`ifdef EXC_STATS_EN
  // Event counters, one bump per commit of the matching class
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_count  <= 32'h0;
      int_count  <= 32'h0;
      eret_count <= 32'h0;
    end else if (evt.hit) begin
      if (evt.is_int) int_count <= int_count + 32'd1;
      else if (evt.is_eret) eret_count <= eret_count + 32'd1;
      else if (!evt.is_ref) exc_count <= exc_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: priority, drain, stalled redirect, reset.
module tb_exc_commit;
  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_bd, ws_eret, ws_refetch;
  logic [31:0] ws_pc, ws_daddr, epc;
  logic [6:0]  ws_exc;
  logic [7:0]  cause_ip, status_im;
  logic        status_ie, status_exl;
  logic [2:0]  outstanding;
  logic        redirect_ready;
  logic        exception_like, is_delay_slot, ws_kill, flush, redirect_valid;
  logic [4:0]  exccode;
  logic [31:0] pc, badvaddr, redirect_pc;
`ifdef EXC_STATS_EN
  logic [31:0] exc_count, int_count, eret_count;
`endif

  int total = 0;
  int bad   = 0;

  exc_commit dut (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_bd(ws_bd),
    .ws_exc(ws_exc), .ws_eret(ws_eret), .ws_refetch(ws_refetch), .ws_daddr(ws_daddr),
    .cause_ip(cause_ip), .status_im(status_im), .status_ie(status_ie),
    .status_exl(status_exl), .epc(epc), .outstanding(outstanding),
    .exception_like(exception_like), .exccode(exccode), .is_delay_slot(is_delay_slot),
    .pc(pc), .badvaddr(badvaddr), .ws_kill(ws_kill), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef EXC_STATS_EN
    .exc_count(exc_count), .int_count(int_count), .eret_count(eret_count),
`endif
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Clear the instruction and let fetch take the redirect
  task automatic take_redirect();
    ws_valid = 0; ws_exc = 0; ws_eret = 0; ws_refetch = 0;
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
  endtask

  initial begin
    reset = 1; ws_valid = 0; ws_pc = 0; ws_bd = 0; ws_exc = 0; ws_eret = 0;
    ws_refetch = 0; ws_daddr = 0; cause_ip = 0; status_im = 0; status_ie = 0;
    status_exl = 0; epc = 0; outstanding = 0; redirect_ready = 0;
    tick(); tick();
    reset = 0; #1;
    chk("rst_el", {31'b0, exception_like}, 0);
    chk("rst_flush", {31'b0, flush}, 0);
    chk("rst_rv", {31'b0, redirect_valid}, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_kill", {31'b0, ws_kill}, 0);

    // Delay-slot interrupt beats Sys
    status_ie = 1; status_im = 8'h80; cause_ip = 8'h80;
    ws_valid = 1; ws_pc = 32'hBFC00100; ws_bd = 1; ws_exc = 7'b0001000; #1;
    chk("int_el", {31'b0, exception_like}, 1);
    chk("int_code", {27'b0, exccode}, 0);
    chk("int_bd", {31'b0, is_delay_slot}, 1);
    chk("int_pc", pc, 32'hBFC00100);
    chk("int_kill", {31'b0, ws_kill}, 1);
    chk("int_bva", badvaddr, 0);
    tick();
    ws_valid = 0; ws_bd = 0; #1;
    chk("int_rv", {31'b0, redirect_valid}, 1);
    chk("int_rpc", redirect_pc, 32'hBFC00380);
    chk("int_no_el", {31'b0, exception_like}, 0);
    take_redirect();
    chk("int_idle_flush", {31'b0, flush}, 0);
    chk("int_idle_rv", {31'b0, redirect_valid}, 0);
    status_ie = 0;

    // Fetch AdEL beats RI
    ws_valid = 1; ws_exc = 7'b0000011; ws_pc = 32'hBFC00102; #1;
    chk("adel_code", {27'b0, exccode}, 4);
    chk("adel_bva", badvaddr, 32'hBFC00102);
    tick(); take_redirect();

    // Ov beats Sys; Bp beats data AdEL and has no badvaddr
    ws_valid = 1; ws_exc = 7'b0001100; ws_pc = 32'hBFC00110; #1;
    chk("ov_code", {27'b0, exccode}, 12);
    tick(); take_redirect();
    ws_valid = 1; ws_exc = 7'b0110000; ws_daddr = 32'h12345678; #1;
    chk("bp_code", {27'b0, exccode}, 9);
    chk("bp_bva", badvaddr, 0);
    tick(); take_redirect();

    // Store address error with drain; valid pulse during DRAIN is ignored
    ws_valid = 1; ws_exc = 7'b1000000; ws_daddr = 32'h80000003; outstanding = 2; #1;
    chk("ades_code", {27'b0, exccode}, 5);
    chk("ades_bva", badvaddr, 32'h80000003);
    tick();
    ws_exc = 7'b0000010; #1;
    chk("drain_no_el", {31'b0, exception_like}, 0);
    chk("drain_flush1", {31'b0, flush}, 1);
    chk("drain_rv1", {31'b0, redirect_valid}, 0);
    tick();
    ws_valid = 0; ws_exc = 0; #1;
    chk("drain_flush2", {31'b0, flush}, 1);
    chk("drain_rv2", {31'b0, redirect_valid}, 0);
    tick();
    outstanding = 0; #1;
    chk("drain_flush3", {31'b0, flush}, 1);
    chk("drain_rv3", {31'b0, redirect_valid}, 0);
    tick();
    chk("drain_rv4", {31'b0, redirect_valid}, 1);
    chk("drain_rpc", redirect_pc, 32'hBFC00380);
    take_redirect();
    chk("drain_idle", {31'b0, flush}, 0);

    // ERET with fetch stalled; target is the commit-cycle epc
    ws_valid = 1; ws_eret = 1; ws_pc = 32'hBFC00120; epc = 32'hBFC00200; #1;
    chk("eret_code", {27'b0, exccode}, 5'h1e);
    chk("eret_kill", {31'b0, ws_kill}, 1);
    tick();
    ws_valid = 0; ws_eret = 0; epc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("eret_rv_stall", {31'b0, redirect_valid}, 1);
      chk("eret_rpc_stall", redirect_pc, 32'hBFC00200);
      tick();
    end
    redirect_ready = 1; #1;
    chk("eret_rv5", {31'b0, redirect_valid}, 1);
    chk("eret_rpc5", redirect_pc, 32'hBFC00200);
    tick();
    redirect_ready = 0; #1;
    chk("eret_idle_rv", {31'b0, redirect_valid}, 0);
    chk("eret_idle_flush", {31'b0, flush}, 0);

    // Refetch, then reset while in REDIRECT
    ws_valid = 1; ws_refetch = 1; ws_pc = 32'hBFC00300; #1;
    chk("ref_code", {27'b0, exccode}, 5'h1f);
    tick();
    ws_valid = 0; ws_refetch = 0; #1;
    chk("ref_rpc", redirect_pc, 32'hBFC00300);
    chk("ref_rv", {31'b0, redirect_valid}, 1);
    reset = 1;
    tick();
    reset = 0; #1;
    chk("rst2_rv", {31'b0, redirect_valid}, 0);
    chk("rst2_flush", {31'b0, flush}, 0);
    chk("rst2_rpc", redirect_pc, 0);

    // Interrupt masked by EXL: clean instruction commits normally
    status_ie = 1; status_exl = 1; status_im = 8'h01; cause_ip = 8'h01;
    ws_valid = 1; ws_pc = 32'hBFC00400; #1;
    chk("mask_el", {31'b0, exception_like}, 0);
    chk("mask_kill", {31'b0, ws_kill}, 0);
    chk("mask_flush", {31'b0, flush}, 0);
    // Exception under EXL is still requested
    ws_exc = 7'b0000100; #1;
    chk("exl_el", {31'b0, exception_like}, 1);
    chk("exl_code", {27'b0, exccode}, 12);
    tick(); take_redirect();
    // Pending interrupt without a valid instruction raises nothing
    status_exl = 0; ws_valid = 0; #1;
    chk("noval_el", {31'b0, exception_like}, 0);
    tick();
    chk("noval_rv", {31'b0, redirect_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
